io_channel_ready_generator: RTL and testbench
=============================================

Name: io_channel_ready_generator

Overview:
- Bus-slave counterpart of the processor ready logic: drives io_channel_ready (IOCHRDY) low to insert wait states when an I/O or memory cycle targets a slow device window.
- Sits on the expansion-bus side of the chipset, next to slow peripherals (e.g. option ROM, slow I/O card); its output feeds the ready logic that stretches CPU and DMA cycles.
- All bus inputs are synchronous to clock.

Parameters:
IO_BASE, 16'h0300, I/O window base address (compared on address[15:0])
IO_MASK, 16'hFFF0, I/O window compare mask (1 = bit compared)
MEM_BASE, 20'hC8000, memory window base address
MEM_MASK, 20'hF8000, memory window compare mask
TIMEOUT_CYCLES, 64, maximum consecutive cycles io_channel_ready may be held low

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  20  bus address
io_read_n  input  1  I/O read strobe, active low
io_write_n  input  1  I/O write strobe, active low
memory_read_n  input  1  memory read strobe, active low
memory_write_n  input  1  memory write strobe, active low
address_enable_n  input  1  low = DMA owns bus (AEN asserted)
wait_count  input  4  wait states to insert per qualified cycle
device_busy  input  1  device extends the wait while high
io_channel_ready  output  1  IOCHRDY to ready logic; 0 = insert wait
wait_active  output  1  high while in WAIT
timeout_flag  output  1  sticky; set when a wait was forced to end by timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE, io_channel_ready=1, wait_active=0, timeout_flag=0, counters=0, strobe history=inactive.
- Clock domain: all state updates on the rising edge of clock. All outputs are registered.
- I/O strobe (io_active): io_read_n=0 or io_write_n=0, qualified only when address_enable_n=1. I/O strobes are ignored during DMA.
- Memory strobe (mem_active): memory_read_n=0 or memory_write_n=0, qualified regardless of address_enable_n.
- Window hits:
  - io_hit = io_active & ((address[15:0] & IO_MASK) == (IO_BASE & IO_MASK)).
  - mem_hit = mem_active & ((address & MEM_MASK) == (MEM_BASE & MEM_MASK)).
- any_active = io_active | mem_active. prev_active is any_active registered.
- start = (io_hit | mem_hit) & ~prev_active. Start is the falling-edge detect of the strobe.
- States:
  - IDLE:
    - On start with wait_count!=0 or device_busy=1: go to WAIT, load wait_cnt=wait_count and to_cnt=1, clear timeout_flag. io_channel_ready=0 from the next edge.
    - On start with wait_count=0 and device_busy=0: go to HOLD. io_channel_ready stays 1 and timeout_flag is cleared.
  - WAIT: io_channel_ready=0, wait_active=1. Each cycle, wait_cnt decrements (saturates at 0) and to_cnt increments. Exits, in priority order:
    1. any_active=0 (strobe withdrawn): go to IDLE, io_channel_ready=1 next edge.
    2. to_cnt==TIMEOUT_CYCLES: go to HOLD, io_channel_ready=1, timeout_flag=1.
    3. wait_cnt reaches 0 this cycle and device_busy=0: go to HOLD, io_channel_ready=1.
  - HOLD: io_channel_ready=1. Stays until any_active=0, then goes to IDLE. A continuously held strobe never retriggers.
- Latency:
  - io_channel_ready falls on the first edge after the strobe falls.
  - With device_busy=0, it is low for exactly wait_count cycles.
  - device_busy high extends the low period cycle-for-cycle beyond wait_count, bounded by TIMEOUT_CYCLES.
- Simultaneous start and strobe release cannot occur, because start requires an active strobe.
- Changes to wait_count during WAIT are ignored; the value is latched at start.
- Reset asserted mid-WAIT releases io_channel_ready to 1 immediately (asynchronous).
- Back-to-back cycles: a new start requires at least one cycle with any_active=0 (passes through IDLE).

Test Plan:
1. wait_count=3, io_read_n low 8 cycles at address 16'h0304, address_enable_n=1 -> io_channel_ready low exactly 3 cycles starting 1 edge after the strobe falls, then 1; wait_active mirrors; timeout_flag=0.
2. Same access at address 16'h0310 (miss), and at 16'h0304 with address_enable_n=0 -> io_channel_ready stays 1 throughout.
3. memory_read_n low at 20'hC8010, wait_count=2, device_busy high for the first 5 cycles -> io_channel_ready low 6 cycles (until the edge after device_busy drops), then 1.
4. wait_count=1, device_busy held 1, strobe held 100 cycles -> io_channel_ready low 64 cycles, then 1; timeout_flag=1 and remains set until the next start, which clears it.
5. wait_count=15, strobe released after 4 cycles -> io_channel_ready returns to 1 on the next edge; state IDLE; a following strobe at 20'hC8000 retriggers a full 15-cycle wait.
6. reset_n pulsed low mid-WAIT -> io_channel_ready=1 and wait_active=0 immediately; with the strobe still held after reset release, a new wait starts only if a prior inactive cycle is registered (prev_active reset to inactive, so it starts).

Source files
------------

// File: rtl/io_channel_ready_generator.sv
// Purpose: drives IOCHRDY low to insert wait states for bus cycles that hit a slow I/O or memory window.
// Latency: IOCHRDY falls on the first edge after a qualified strobe falls and stays low wait_count cycles (longer while device_busy is high, bounded by TIMEOUT_CYCLES).
// Backpressure: none accepted; the block is itself the backpressure source for the CPU/DMA ready logic.
module io_channel_ready_generator #(
    parameter logic [15:0] IO_BASE        = 16'h0300,
    parameter logic [15:0] IO_MASK        = 16'hFFF0,
    parameter logic [19:0] MEM_BASE       = 20'hC8000,
    parameter logic [19:0] MEM_MASK       = 20'hF8000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic        io_read_n,
    input  logic        io_write_n,
    input  logic        memory_read_n,
    input  logic        memory_write_n,
    input  logic        address_enable_n,
    input  logic [3:0]  wait_count,
    input  logic        device_busy,
    output logic        io_channel_ready,
    output logic        wait_active,
    output logic        timeout_flag
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_flag_q, timeout_flag_d;
    logic            ready_q;
    logic            wait_active_q;
    logic            prev_active_q;

    // Strobe qualification: I/O strobes belong to the DMA controller while AEN is asserted.
    logic io_active, mem_active, any_active;
    logic io_hit, mem_hit, start;
    logic [3:0] wait_cnt_dec;

    assign io_active  = (~io_read_n | ~io_write_n) & address_enable_n;
    assign mem_active = ~memory_read_n | ~memory_write_n;
    assign any_active = io_active | mem_active;
    assign io_hit     = io_active  & ((address[15:0] & IO_MASK)  == (IO_BASE  & IO_MASK));
    assign mem_hit    = mem_active & ((address       & MEM_MASK) == (MEM_BASE & MEM_MASK));
    // Only the falling edge of a strobe starts a wait, so a held strobe never retriggers.
    assign start      = (io_hit | mem_hit) & ~prev_active_q;
    assign wait_cnt_dec = (wait_cnt_q == 4'd0) ? 4'd0 : (wait_cnt_q - 4'd1);

    // Next-state logic: counters and sticky timeout flag follow the FSM.
    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        to_cnt_d       = to_cnt_q;
        timeout_flag_d = timeout_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    timeout_flag_d = 1'b0;
                    if ((wait_count != 4'd0) || device_busy) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = wait_count;
                        to_cnt_d   = TO_ONE;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_dec;
                to_cnt_d   = to_cnt_q + TO_ONE;
                if (!any_active) begin
                    // Strobe withdrawn: abandon the wait and release the bus.
                    state_d    = ST_IDLE;
                    wait_cnt_d = 4'd0;
                    to_cnt_d   = '0;
                end else if (to_cnt_q == TO_LIMIT) begin
                    // Device held the bus too long: force the cycle to finish.
                    state_d        = ST_HOLD;
                    timeout_flag_d = 1'b1;
                    wait_cnt_d     = 4'd0;
                    to_cnt_d       = '0;
                end else if ((wait_cnt_dec == 4'd0) && !device_busy) begin
                    state_d    = ST_HOLD;
                    wait_cnt_d = 4'd0;
                    to_cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (!any_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 4'd0;
                to_cnt_d   = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset releases IOCHRDY immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= 4'd0;
            to_cnt_q       <= '0;
            timeout_flag_q <= 1'b0;
            ready_q        <= 1'b1;
            wait_active_q  <= 1'b0;
            prev_active_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            to_cnt_q       <= to_cnt_d;
            timeout_flag_q <= timeout_flag_d;
            ready_q        <= (state_d != ST_WAIT);
            wait_active_q  <= (state_d == ST_WAIT);
            prev_active_q  <= any_active;
        end
    end

    assign io_channel_ready = ready_q;
    assign wait_active      = wait_active_q;
    assign timeout_flag     = timeout_flag_q;

endmodule

// File: tb/tb_io_channel_ready_generator.sv
module tb_io_channel_ready_generator;

    logic        clock;
    logic        reset_n;
    logic [19:0] address;
    logic        io_read_n, io_write_n, memory_read_n, memory_write_n;
    logic        address_enable_n;
    logic [3:0]  wait_count;
    logic        device_busy;
    logic        io_channel_ready, wait_active, timeout_flag;

    io_channel_ready_generator dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .address          (address),
        .io_read_n        (io_read_n),
        .io_write_n       (io_write_n),
        .memory_read_n    (memory_read_n),
        .memory_write_n   (memory_write_n),
        .address_enable_n (address_enable_n),
        .wait_count       (wait_count),
        .device_busy      (device_busy),
        .io_channel_ready (io_channel_ready),
        .wait_active      (wait_active),
        .timeout_flag     (timeout_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] test_id;
        logic       rdy;
        logic       wa;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   test_id  = 0;
    bit   done     = 1'b0;

    // Monitor: each falling edge, compare the outputs against the next expected entry.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({io_channel_ready, wait_active, timeout_flag} !== {e.rdy, e.wa, e.to}) begin
                failures++;
                $display("FAIL test%0d t=%0t rdy/wa/to actual=%b%b%b required=%b%b%b",
                         e.test_id, $time, io_channel_ready, wait_active, timeout_flag,
                         e.rdy, e.wa, e.to);
            end
        end
    end

    task automatic push_exp(input bit r, input bit wa, input bit to);
        exp_t e;
        e.test_id = 8'(test_id);
        e.rdy = r;
        e.wa  = wa;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    // One clock: the expectation describes outputs after this rising edge.
    task automatic run(input int n, input bit r, input bit wa, input bit to);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            push_exp(r, wa, to);
        end
    endtask

    task automatic strobes_off();
        io_read_n = 1'b1; io_write_n = 1'b1;
        memory_read_n = 1'b1; memory_write_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        address = 20'h00304;
        strobes_off();
        address_enable_n = 1'b1;
        wait_count = 4'd3;
        device_busy = 1'b0;

        // Reset state
        #1;
        push_exp(1'b1, 1'b0, 1'b0);
        #11;
        reset_n = 1'b1;
        run(2, 1'b1, 1'b0, 1'b0);

        // 1: I/O read hit, 3 wait states
        test_id = 1;
        io_read_n = 1'b0;
        run(3, 1'b0, 1'b1, 1'b0);
        run(5, 1'b1, 1'b0, 1'b0);
        strobes_off();
        run(2, 1'b1, 1'b0, 1'b0);

        // 2: window miss, then DMA-owned bus
        test_id = 2;
        address = 20'h00310;
        io_read_n = 1'b0;
        run(8, 1'b1, 1'b0, 1'b0);
        strobes_off();
        run(1, 1'b1, 1'b0, 1'b0);
        address = 20'h00304;
        address_enable_n = 1'b0;
        io_read_n = 1'b0;
        run(8, 1'b1, 1'b0, 1'b0);
        strobes_off();
        address_enable_n = 1'b1;
        run(1, 1'b1, 1'b0, 1'b0);

        // 3: memory read, device_busy extends the wait
        test_id = 3;
        address = 20'hC8010;
        wait_count = 4'd2;
        device_busy = 1'b1;
        memory_read_n = 1'b0;
        run(6, 1'b0, 1'b1, 1'b0);
        device_busy = 1'b0;
        run(3, 1'b1, 1'b0, 1'b0);
        strobes_off();
        run(2, 1'b1, 1'b0, 1'b0);

        // 4: timeout after 64 low cycles; flag sticky until next start
        test_id = 4;
        address = 20'h00304;
        wait_count = 4'd1;
        device_busy = 1'b1;
        io_write_n = 1'b0;
        run(64, 1'b0, 1'b1, 1'b0);
        run(36, 1'b1, 1'b0, 1'b1);
        strobes_off();
        device_busy = 1'b0;
        run(3, 1'b1, 1'b0, 1'b1);
        wait_count = 4'd0;
        io_read_n = 1'b0;
        run(2, 1'b1, 1'b0, 1'b0);
        strobes_off();
        run(2, 1'b1, 1'b0, 1'b0);

        // 5: strobe withdrawn early, then full 15-cycle retrigger
        test_id = 5;
        address = 20'hC8010;
        wait_count = 4'd15;
        memory_write_n = 1'b0;
        run(4, 1'b0, 1'b1, 1'b0);
        strobes_off();
        run(1, 1'b1, 1'b0, 1'b0);
        address = 20'hC8000;
        memory_read_n = 1'b0;
        run(3, 1'b0, 1'b1, 1'b0);
        wait_count = 4'd2;
        run(12, 1'b0, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        strobes_off();
        run(2, 1'b1, 1'b0, 1'b0);

        // 6: async reset mid-wait, restart with strobe still held
        test_id = 6;
        address = 20'h00304;
        wait_count = 4'd5;
        io_read_n = 1'b0;
        run(2, 1'b0, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        push_exp(1'b1, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        push_exp(1'b1, 1'b0, 1'b0);
        #1;
        reset_n = 1'b1;
        run(5, 1'b0, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b0);
        strobes_off();
        run(2, 1'b1, 1'b0, 1'b0);

        @(posedge clock);
        @(posedge clock);
        done = 1'b1;
    end

    // Finish once stimulus is done, with a hard time bound as a safety net.
    initial begin
        fork
            wait (done);
            #200000;
        join_any
        disable fork;
        checks++;
        if (!done || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain done=%0d pending=%0d required done=1 pending=0", done, exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
